img_frame_reader: RTL and testbench

IMG_FRAME_READER -- requirements
Module: img_frame_reader

---
 rtl/img_pkg.sv | 25 ++
 rtl/img_frame_reader_if.sv | 48 ++++
 rtl/px_skid_buf.sv | 64 ++++++
 rtl/img_frame_reader.sv | 215 +++++++++++++++++++++
 tb/tb_img_frame_reader.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/img_pkg.sv
// Shared image geometry defaults, reader FSM encoding and pixel record for the frame reader, NN and canvas blocks.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package img_pkg;

    localparam int IMG_W_DEF  = 28;
    localparam int IMG_H_DEF  = 28;
    localparam int ADDR_W_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_t;

    // One pixel travelling from the RAM read port to the consumer, with its coordinates.
    typedef struct packed {
        logic       data;
        logic [4:0] row;
        logic [4:0] col;
        logic       last;
    } px_t;

endpackage

// File: rtl/img_frame_reader_if.sv
// Bundle of the frame reader's control, RAM read port, pixel stream and ink count (plus bbox outputs when IMG_FRAME_READER_BBOX_EN).
// Latency: none (wiring only).
// Backpressure: px_valid/px_ready on the pixel stream; the RAM port has fixed one-cycle read latency.
interface img_frame_reader_if #(
    parameter int ADDR_W = img_pkg::ADDR_W_DEF
) ();

    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_data;
    logic              px_valid;
    logic              px_ready;
    logic              px_data;
    logic [4:0]        px_row;
    logic [4:0]        px_col;
    logic              px_last;
    logic [ADDR_W-1:0] ink_count;
`ifdef IMG_FRAME_READER_BBOX_EN
    logic              bbox_valid;
    logic [4:0]        bbox_rmin;
    logic [4:0]        bbox_rmax;
    logic [4:0]        bbox_cmin;
    logic [4:0]        bbox_cmax;

    modport master (
        input  start, rd_data, px_ready,
        output busy, done, rd_addr, px_valid, px_data, px_row, px_col, px_last, ink_count,
        output bbox_valid, bbox_rmin, bbox_rmax, bbox_cmin, bbox_cmax
    );
    modport slave (
        output start, rd_data, px_ready,
        input  busy, done, rd_addr, px_valid, px_data, px_row, px_col, px_last, ink_count,
        input  bbox_valid, bbox_rmin, bbox_rmax, bbox_cmin, bbox_cmax
    );
`else
    modport master (
        input  start, rd_data, px_ready,
        output busy, done, rd_addr, px_valid, px_data, px_row, px_col, px_last, ink_count
    );
    modport slave (
        output start, rd_data, px_ready,
        input  busy, done, rd_addr, px_valid, px_data, px_row, px_col, px_last, ink_count
    );
`endif

endinterface

// File: rtl/px_skid_buf.sv
// Two-entry pixel queue with pass-through when empty, between the RAM read return and the pixel consumer.
// Latency: 0 cycles when empty and out_rdy_i is high, otherwise the pixel waits in the queue.
// Backpressure: holds the head stable while out_rdy_i is low; the producer must keep occupancy + in-flight below 2.
module px_skid_buf
    import img_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_vld_i,
    input  px_t        in_dat_i,
    input  logic       out_rdy_i,
    output logic       out_vld_o,
    output px_t        out_dat_o,
    output logic [1:0] occ_o
);

    px_t        mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] cnt_q;
    logic       push;
    logic       pop;

    // Incoming pixels bypass the storage only when nothing is queued ahead and the consumer takes them now.
    assign pop       = (cnt_q != 2'd0) && out_rdy_i;
    assign push      = in_vld_i && !((cnt_q == 2'd0) && out_rdy_i);
    assign out_vld_o = (cnt_q != 2'd0) || in_vld_i;
    assign occ_o     = cnt_q;

    // Present the oldest pixel; zero when idle so the outputs read 0 out of reset.
    always_comb begin
        out_dat_o = '0;
        if (cnt_q != 2'd0) begin
            out_dat_o = mem_q[rd_ptr_q];
        end else if (in_vld_i) begin
            out_dat_o = in_dat_i;
        end
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_dat_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/img_frame_reader.sv
// Scans an IMG_W x IMG_H 1-bit image RAM row-major into a pixel stream, counting ink pixels; IMG_FRAME_READER_BBOX_EN adds an ink bounding box.
// Latency: first pixel valid 2 cycles after start, one pixel per cycle at full rate, done 1 cycle after the last transfer.
// Backpressure: px_ready low stalls the stream; reads are throttled so the 2-entry queue never overflows.
module img_frame_reader
    import img_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    img_frame_reader_if.master bus
);

    localparam int                NPIX     = IMG_W * IMG_H;
    localparam logic [4:0]        LAST_ROW = 5'(IMG_H - 1);
    localparam logic [4:0]        LAST_COL = 5'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] INK_MAX  = ADDR_W'(NPIX);

    rd_state_t         state_q, state_d;
    logic [4:0]        row_q, row_d, col_q, col_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              infl_q, infl_d;
    logic [4:0]        infl_row_q, infl_row_d, infl_col_q, infl_col_d;
    logic              infl_last_q, infl_last_d;
    logic [ADDR_W-1:0] ink_q, ink_d;
    logic              busy, done;
    logic              start_acc, room, issue, last_issue, xfer, xfer_last;
    logic [1:0]        occ;
    logic              out_vld;
    px_t               in_px, out_px;

    assign start_acc  = (state_q == ST_IDLE) && bus.start;
    // A read is only issued when its data is guaranteed a queue slot, counting the read still in flight.
    assign room       = ({1'b0, occ} + {2'b00, infl_q}) < 3'd2;
    assign issue      = (state_q == ST_READ) && room;
    assign last_issue = issue && (row_q == LAST_ROW) && (col_q == LAST_COL);
    assign xfer       = out_vld && bus.px_ready;
    assign xfer_last  = xfer && out_px.last;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: reads run until the last address is out, then wait for the last pixel to leave.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_acc)  state_d = ST_READ;
            ST_READ:  if (last_issue) state_d = ST_DRAIN;
            ST_DRAIN: if (xfer_last)  state_d = ST_DONE;
            ST_DONE:                  state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_READ, ST_DRAIN: busy = 1'b1;
            ST_DONE:           done = 1'b1;
            default:           ;
        endcase
    end

    // Address sequencer: row/col counters plus the linear address, and the tag of the read in flight.
    always_comb begin
        row_d       = row_q;
        col_d       = col_q;
        addr_d      = addr_q;
        infl_d      = issue;
        infl_row_d  = infl_row_q;
        infl_col_d  = infl_col_q;
        infl_last_d = infl_last_q;
        if (start_acc) begin
            row_d  = '0;
            col_d  = '0;
            addr_d = '0;
        end else if (issue) begin
            infl_row_d  = row_q;
            infl_col_d  = col_q;
            infl_last_d = last_issue;
            if (!last_issue) begin
                addr_d = addr_q + ADDR_W'(1);
                if (col_q == LAST_COL) begin
                    col_d = '0;
                    row_d = row_q + 5'd1;
                end else begin
                    col_d = col_q + 5'd1;
                end
            end
        end
    end

    // Ink counter: cleared on start, saturates at the pixel count.
    always_comb begin
        ink_d = ink_q;
        if (start_acc) begin
            ink_d = '0;
        end else if (xfer && out_px.data && (ink_q != INK_MAX)) begin
            ink_d = ink_q + ADDR_W'(1);
        end
    end

    // Sequencer and counter registers; reset drops any read in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q       <= '0;
            col_q       <= '0;
            addr_q      <= '0;
            infl_q      <= 1'b0;
            infl_row_q  <= '0;
            infl_col_q  <= '0;
            infl_last_q <= 1'b0;
            ink_q       <= '0;
        end else begin
            row_q       <= row_d;
            col_q       <= col_d;
            addr_q      <= addr_d;
            infl_q      <= infl_d;
            infl_row_q  <= infl_row_d;
            infl_col_q  <= infl_col_d;
            infl_last_q <= infl_last_d;
            ink_q       <= ink_d;
        end
    end

    assign in_px = '{data: bus.rd_data, row: infl_row_q, col: infl_col_q, last: infl_last_q};

    px_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_vld_i  (infl_q),
        .in_dat_i  (in_px),
        .out_rdy_i (bus.px_ready),
        .out_vld_o (out_vld),
        .out_dat_o (out_px),
        .occ_o     (occ)
    );

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.rd_addr   = addr_q;
    assign bus.px_valid  = out_vld;
    assign bus.px_data   = out_px.data;
    assign bus.px_row    = out_px.row;
    assign bus.px_col    = out_px.col;
    assign bus.px_last   = out_px.last;
    assign bus.ink_count = ink_q;

`ifdef IMG_FRAME_READER_BBOX_EN
    logic [4:0] rmin_q, rmin_d, rmax_q, rmax_d, cmin_q, cmin_d, cmax_q, cmax_d;
    logic       bbv_q, bbv_d;

    // Bounding box: the first ink pixel seeds all four edges, later ones widen them; valid rises with done.
    always_comb begin
        rmin_d = rmin_q;
        rmax_d = rmax_q;
        cmin_d = cmin_q;
        cmax_d = cmax_q;
        bbv_d  = bbv_q;
        if (start_acc) begin
            rmin_d = '0;
            rmax_d = '0;
            cmin_d = '0;
            cmax_d = '0;
            bbv_d  = 1'b0;
        end else begin
            if (xfer && out_px.data) begin
                if (ink_q == '0) begin
                    rmin_d = out_px.row;
                    rmax_d = out_px.row;
                    cmin_d = out_px.col;
                    cmax_d = out_px.col;
                end else begin
                    if (out_px.row < rmin_q) rmin_d = out_px.row;
                    if (out_px.row > rmax_q) rmax_d = out_px.row;
                    if (out_px.col < cmin_q) cmin_d = out_px.col;
                    if (out_px.col > cmax_q) cmax_d = out_px.col;
                end
            end
            if (xfer_last && (ink_d != '0)) bbv_d = 1'b1;
        end
    end

    // Bounding box registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rmin_q <= '0;
            rmax_q <= '0;
            cmin_q <= '0;
            cmax_q <= '0;
            bbv_q  <= 1'b0;
        end else begin
            rmin_q <= rmin_d;
            rmax_q <= rmax_d;
            cmin_q <= cmin_d;
            cmax_q <= cmax_d;
            bbv_q  <= bbv_d;
        end
    end

    assign bus.bbox_valid = bbv_q;
    assign bus.bbox_rmin  = rmin_q;
    assign bus.bbox_rmax  = rmax_q;
    assign bus.bbox_cmin  = cmin_q;
    assign bus.bbox_cmax  = cmax_q;
`endif

endmodule

// File: tb/tb_img_frame_reader.sv
// Self-checking bench for img_frame_reader: scoreboard of expected pixels per frame, compared on each transfer.
// Latency: checks first-valid at 2 cycles, back-to-back transfers at full rate, done 1 cycle after the last pixel.
// Backpressure: random px_ready stalls with output-hold checks; reset mid-frame and ignored re-start.
module tb_img_frame_reader;
    import img_pkg::*;

    localparam int W    = 28;
    localparam int H    = 28;
    localparam int AW   = 10;
    localparam int NPIX = W * H;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    img_frame_reader_if #(.ADDR_W(AW)) bus ();

    img_frame_reader #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Image RAM model: data for the presented address appears one cycle later.
    logic ram [0:1023];
    always @(posedge clk) bus.rd_data <= ram[bus.rd_addr];

    int          errors = 0;
    int          checks = 0;
    logic [11:0] exp_q[$];
    logic [31:0] ink_at_done;
`ifdef IMG_FRAME_READER_BBOX_EN
    logic [4:0]  bb_rmin_s, bb_rmax_s, bb_cmin_s, bb_cmax_s;
    logic        bb_v_s;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one frame from a start pulse; optional re-start pulse or reset at a given transfer count.
    task automatic run_frame(input string nm, input bit rnd, input int restart_at, input int abort_at);
        int          cyc, first_v, last_x, lastpx_c, done_c, ndone, nx, ink_exp;
        bit          prev_stall, restarted;
        logic [11:0] cur, prev_px;
`ifdef IMG_FRAME_READER_BBOX_EN
        logic [4:0]  e_rmin, e_rmax, e_cmin, e_cmax;
`endif
        ink_exp = 0;
        exp_q.delete();
        for (int i = 0; i < NPIX; i++) begin
            exp_q.push_back({ram[i], 5'(i / W), 5'(i % W), (i == NPIX - 1)});
            if (ram[i]) ink_exp++;
        end
        @(negedge clk);
        bus.start    = 1'b1;
        bus.px_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        cyc = 0; first_v = -1; last_x = -1; lastpx_c = -1; done_c = -1;
        ndone = 0; nx = 0; prev_stall = 1'b0; restarted = 1'b0; prev_px = '0;
        while (done_c < 0 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            bus.start    = 1'b0;
            bus.px_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (restart_at >= 0 && nx == restart_at && !restarted) begin
                bus.start = 1'b1;
                restarted = 1'b1;
            end
            if (abort_at >= 0 && nx == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check({nm, "_rst_vld"}, 32'(bus.px_valid), 0);
                check({nm, "_rst_busy"}, 32'(bus.busy), 0);
                check({nm, "_rst_ink"}, 32'(bus.ink_count), 0);
                exp_q.delete();
                return;
            end
            cur = {bus.px_data, bus.px_row, bus.px_col, bus.px_last};
            if (cyc == 1) begin
                check({nm, "_addr0"}, 32'(bus.rd_addr), 0);
                check({nm, "_busy1"}, 32'(bus.busy), 1);
            end
            if (prev_stall) check({nm, "_hold"}, 32'({bus.px_valid, cur}), 32'({1'b1, prev_px}));
            if (bus.px_valid && first_v < 0) first_v = cyc;
            if (bus.done) begin
                ndone++;
                done_c      = cyc;
                ink_at_done = 32'(bus.ink_count);
`ifdef IMG_FRAME_READER_BBOX_EN
                bb_rmin_s = bus.bbox_rmin; bb_rmax_s = bus.bbox_rmax;
                bb_cmin_s = bus.bbox_cmin; bb_cmax_s = bus.bbox_cmax;
                bb_v_s    = bus.bbox_valid;
`endif
            end
            if (bus.px_valid && bus.px_ready) begin
                if (exp_q.size() == 0) check({nm, "_extra_px"}, 32'(cur), 32'hFFFF_FFFF);
                else                   check({nm, "_px"}, 32'(cur), 32'(exp_q.pop_front()));
                nx++;
                last_x = cyc;
                if (bus.px_last) lastpx_c = cyc;
            end
            prev_stall = bus.px_valid && !bus.px_ready;
            prev_px    = cur;
        end
        check({nm, "_done_seen"}, 32'(done_c >= 0), 1);
        check({nm, "_count"}, 32'(nx), NPIX);
        check({nm, "_left"}, 32'(exp_q.size()), 0);
        check({nm, "_done_gap"}, 32'(done_c - lastpx_c), 1);
        check({nm, "_ink"}, ink_at_done, 32'(ink_exp));
        if (!rnd) begin
            check({nm, "_first"}, 32'(first_v), 2);
            check({nm, "_burst"}, 32'(last_x - first_v), NPIX - 1);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check({nm, "_ndone"}, 32'(ndone), 1);
        check({nm, "_idle"}, 32'(bus.busy), 0);
        check({nm, "_ink_hold"}, 32'(bus.ink_count), 32'(ink_exp));
`ifdef IMG_FRAME_READER_BBOX_EN
        e_rmin = 5'd31; e_rmax = 5'd0; e_cmin = 5'd31; e_cmax = 5'd0;
        for (int i = 0; i < NPIX; i++) begin
            if (ram[i]) begin
                if (5'(i / W) < e_rmin) e_rmin = 5'(i / W);
                if (5'(i / W) > e_rmax) e_rmax = 5'(i / W);
                if (5'(i % W) < e_cmin) e_cmin = 5'(i % W);
                if (5'(i % W) > e_cmax) e_cmax = 5'(i % W);
            end
        end
        if (ink_exp == 0) begin
            e_rmin = '0; e_rmax = '0; e_cmin = '0; e_cmax = '0;
        end
        check({nm, "_bb_v"}, 32'(bb_v_s), 32'(ink_exp > 0));
        check({nm, "_bb_box"}, {12'd0, bb_rmin_s, bb_rmax_s, bb_cmin_s, bb_cmax_s},
              {12'd0, e_rmin, e_rmax, e_cmin, e_cmax});
`endif
    endtask

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.px_ready = 1'b0;
        for (int i = 0; i < 1024; i++) ram[i] = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_vld", 32'(bus.px_valid), 0);
        check("rst_pix", 32'({bus.px_data, bus.px_last, bus.px_row, bus.px_col}), 0);
        check("rst_addr", 32'(bus.rd_addr), 0);
        check("rst_ink", 32'(bus.ink_count), 0);
`ifdef IMG_FRAME_READER_BBOX_EN
        check("rst_bbox", 32'({bus.bbox_valid, bus.bbox_rmin, bus.bbox_rmax, bus.bbox_cmin, bus.bbox_cmax}), 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // start together with reset: reset wins, nothing starts
        rst = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        check("rst_start_busy", 32'(bus.busy), 0);
        @(negedge clk);
        check("rst_start_busy2", 32'(bus.busy), 0);

        run_frame("zero", 1'b0, -1, -1);

        ram[29]  = 1'b1;
        ram[754] = 1'b1;
        run_frame("two", 1'b0, -1, -1);
        check("two_ink", ink_at_done, 2);
`ifdef IMG_FRAME_READER_BBOX_EN
        check("two_bb", {11'd0, bb_v_s, bb_rmin_s, bb_rmax_s, bb_cmin_s, bb_cmax_s},
              {11'd0, 1'b1, 5'd1, 5'd26, 5'd1, 5'd26});
`endif

        for (int i = 0; i < NPIX; i++) ram[i] = ($urandom_range(0, 9) < 3);
        run_frame("stall", 1'b1, -1, -1);
        run_frame("rst300", 1'b0, -1, 300);
        run_frame("rescan", 1'b0, -1, -1);
        run_frame("restart", 1'b0, 100, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
